// File: rtl/kernel_cpu_cpu_oci_trace_capture_if.sv
// Trace-capture bus: DCT word stream in, valid/ready host read port out.
interface kernel_cpu_cpu_oci_trace_capture_if #(
  parameter int DATA_W = 30
);
  logic              dct_valid;
  logic [DATA_W-1:0] dct_buffer;
  logic              rd_ready;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;

  // Side that produces trace words and consumes the read port.
  modport master (
    output dct_valid, dct_buffer, rd_ready,
    input  rd_valid, rd_data
  );

  // Capture buffer side.
  modport slave (
    input  dct_valid, dct_buffer, rd_ready,
    output rd_valid, rd_data
  );
endinterface

// File: rtl/kernel_cpu_cpu_oci_trace_capture.sv
// OCI DCT trace capture: circular buffer with FWFT read port, overflow and
// dropped-word tracking, and a capture -> drain -> done end-of-test sequence.
//
// state   | meaning
// CAPTURE | words accepted from the OCI stream
// DRAIN   | input ignored, host empties the buffer
// DONE    | buffer drained, test_has_ended held until reset
module kernel_cpu_cpu_oci_trace_capture #(
  parameter int DATA_W    = 30,
  parameter int ADDR_W    = 4,
  parameter int WRAP_MODE = 0,
  parameter int DROP_W    = 16
) (
  input  logic                              clk,
  input  logic                              reset_n,
  kernel_cpu_cpu_oci_trace_capture_if.slave bus,
  input  logic                              test_ending_i,
  output logic [ADDR_W:0]                   dct_count_o,
  output logic                              overflow_o,
  output logic [DROP_W-1:0]                 dropped_count_o,
  output logic                              test_has_ended_o
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    CAPTURE = 2'd0,
    DRAIN   = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   wr_q, wr_d;
  logic [ADDR_W-1:0]   rd_q, rd_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                ovf_q, ovf_d;
  logic [DROP_W-1:0]   drop_q, drop_d;
  logic                ended_q, ended_d;
  logic                we;
  logic                push, pop, full;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  assign push = bus.dct_valid && (state_q == CAPTURE);
  assign pop  = (count_q != '0) && bus.rd_ready;
  assign full = (count_q == FULL_CNT);

  // Next-state for pointers, fill level, loss tracking and sequencer.
  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    drop_d  = drop_q;
    ended_d = ended_q;
    we      = 1'b0;

    if (push) begin
      if (!full || pop) begin
        we   = 1'b1;
        wr_d = wr_q + 1'b1;
        if (pop) rd_d = rd_q + 1'b1;
        else     count_d = count_q + 1'b1;
      end else begin
        // Full with no room freed: word is lost either way, oldest or newest.
        ovf_d = 1'b1;
        if (drop_q != '1) drop_d = drop_q + 1'b1;
        if (WRAP_MODE != 0) begin
          we   = 1'b1;
          wr_d = wr_q + 1'b1;
          rd_d = rd_q + 1'b1;
        end
      end
    end else if (pop) begin
      rd_d    = rd_q + 1'b1;
      count_d = count_q - 1'b1;
    end

    case (state_q)
      CAPTURE: if (test_ending_i) state_d = DRAIN;
      DRAIN: begin
        if (count_d == '0) begin
          state_d = DONE;
          ended_d = 1'b1;
        end
      end
      DONE:    state_d = DONE;
      default: state_d = CAPTURE;
    endcase
  end

  // Control and status registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= CAPTURE;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      drop_q  <= '0;
      ended_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      drop_q  <= drop_d;
      ended_q <= ended_d;
    end
  end

  // Storage array; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (we && reset_n) mem_q[wr_q] <= bus.dct_buffer;
  end

  assign bus.rd_valid     = (count_q != '0);
  assign bus.rd_data      = mem_q[rd_q];
  assign dct_count_o      = count_q;
  assign overflow_o       = ovf_q;
  assign dropped_count_o  = drop_q;
  assign test_has_ended_o = ended_q;

endmodule

// File: tb/tb_kernel_cpu_cpu_oci_trace_capture.sv
// Bench for the trace capture buffer: one drop-mode and one wrap-mode unit,
// queue scoreboards holding the words each unit should hand back.
module tb_kernel_cpu_cpu_oci_trace_capture;

  logic clk = 1'b0;
  logic reset_n;
  logic te_a, te_b;
  logic [4:0]  cnt_a, cnt_b;
  logic        ovf_a, ovf_b;
  logic [15:0] drp_a, drp_b;
  logic        end_a, end_b;

  int n_tests = 0;
  int n_fail  = 0;

  logic [29:0] sb_a[$];
  logic [29:0] sb_b[$];

  kernel_cpu_cpu_oci_trace_capture_if #(.DATA_W(30)) ifa ();
  kernel_cpu_cpu_oci_trace_capture_if #(.DATA_W(30)) ifb ();

  kernel_cpu_cpu_oci_trace_capture #(.DATA_W(30), .ADDR_W(4), .WRAP_MODE(0), .DROP_W(16)) dut_a (
    .clk(clk), .reset_n(reset_n), .bus(ifa), .test_ending_i(te_a),
    .dct_count_o(cnt_a), .overflow_o(ovf_a), .dropped_count_o(drp_a), .test_has_ended_o(end_a)
  );

  kernel_cpu_cpu_oci_trace_capture #(.DATA_W(30), .ADDR_W(4), .WRAP_MODE(1), .DROP_W(16)) dut_b (
    .clk(clk), .reset_n(reset_n), .bus(ifb), .test_ending_i(te_b),
    .dct_count_o(cnt_b), .overflow_o(ovf_b), .dropped_count_o(drp_b), .test_has_ended_o(end_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ifa.dct_valid = 1'b0; ifa.dct_buffer = '0; ifa.rd_ready = 1'b0; te_a = 1'b0;
    ifb.dct_valid = 1'b0; ifb.dct_buffer = '0; ifb.rd_ready = 1'b0; te_b = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    sb_a.delete();
    sb_b.delete();
  endtask

  // Expected-content model: a bounded queue with the two full policies.
  task automatic model_push(input int u, input logic [29:0] d);
    if (u == 0) begin
      if (sb_a.size() < 16) sb_a.push_back(d);
    end else begin
      if (sb_b.size() >= 16) void'(sb_b.pop_front());
      sb_b.push_back(d);
    end
  endtask

  // One cycle of pushing d into the units selected by mask (bit0=a, bit1=b).
  task automatic push(input logic [29:0] d, input logic [1:0] mask);
    ifa.dct_valid = mask[0]; ifa.dct_buffer = d;
    ifb.dct_valid = mask[1]; ifb.dct_buffer = d;
    if (mask[0]) model_push(0, d);
    if (mask[1]) model_push(1, d);
    tick();
    ifa.dct_valid = 1'b0;
    ifb.dct_valid = 1'b0;
  endtask

  // Read n words back-to-back, comparing each against the scoreboard.
  task automatic drain(input int u, input int n);
    logic [29:0] exp;
    for (int i = 0; i < n; i++) begin
      if (u == 0) begin
        ifa.rd_ready = 1'b1;
        check("rd_valid_a", ifa.rd_valid, 1'b1);
        exp = (sb_a.size() != 0) ? sb_a.pop_front() : 30'h0;
        check("rd_data_a", ifa.rd_data, exp);
      end else begin
        ifb.rd_ready = 1'b1;
        check("rd_valid_b", ifb.rd_valid, 1'b1);
        exp = (sb_b.size() != 0) ? sb_b.pop_front() : 30'h0;
        check("rd_data_b", ifb.rd_data, exp);
      end
      tick();
    end
    ifa.rd_ready = 1'b0;
    ifb.rd_ready = 1'b0;
  endtask

  initial begin
    logic [29:0] exp;
    idle_inputs();
    reset_n = 1'b0;
    tick();
    do_reset();

    // Reset state
    check("rst_count_a", cnt_a, 5'd0);
    check("rst_valid_a", ifa.rd_valid, 1'b0);
    check("rst_ovf_a", ovf_a, 1'b0);
    check("rst_drop_a", drp_a, 16'd0);
    check("rst_ended_a", end_a, 1'b0);
    check("rst_count_b", cnt_b, 5'd0);

    // Basic FIFO order
    for (int i = 0; i < 10; i++) push(30'(i), 2'b01);
    check("basic_count", cnt_a, 5'd10);
    check("basic_head", ifa.rd_data, 30'h0);
    drain(0, 10);
    check("basic_empty", cnt_a, 5'd0);
    check("basic_valid0", ifa.rd_valid, 1'b0);
    check("basic_ovf", ovf_a, 1'b0);

    // Drop vs wrap with 20 words into 16 entries
    do_reset();
    for (int i = 1; i <= 20; i++) push(30'(i), 2'b11);
    check("drop_count", cnt_a, 5'd16);
    check("drop_ovf", ovf_a, 1'b1);
    check("drop_dropped", drp_a, 16'd4);
    check("wrap_count", cnt_b, 5'd16);
    check("wrap_ovf", ovf_b, 1'b1);
    check("wrap_dropped", drp_b, 16'd4);
    drain(0, 16);
    drain(1, 16);
    check("drop_after", cnt_a, 5'd0);
    check("wrap_after", cnt_b, 5'd0);

    // Full with simultaneous push and pop
    do_reset();
    for (int i = 1; i <= 16; i++) push(30'(i), 2'b01);
    ifa.rd_ready = 1'b1;
    exp = sb_a.pop_front();
    check("fullpp_head", ifa.rd_data, exp);
    push(30'h3FFFFFFF, 2'b01);
    ifa.rd_ready = 1'b0;
    check("fullpp_count", cnt_a, 5'd16);
    check("fullpp_drop", drp_a, 16'd0);
    check("fullpp_ovf", ovf_a, 1'b0);
    drain(0, 16);

    // End of test with 3 words; third word pushed in the test_ending cycle
    do_reset();
    push(30'h101, 2'b01);
    push(30'h102, 2'b01);
    te_a = 1'b1;
    push(30'h103, 2'b01);
    te_a = 1'b0;
    ifa.dct_valid = 1'b1; ifa.dct_buffer = 30'h1EE;
    tick(); tick();
    check("eot_count", cnt_a, 5'd3);
    check("eot_ended0", end_a, 1'b0);
    drain(0, 2);
    check("eot_ended_2pops", end_a, 1'b0);
    drain(0, 1);
    check("eot_ended", end_a, 1'b1);
    check("eot_valid", ifa.rd_valid, 1'b0);
    te_a = 1'b1;
    tick(); tick();
    te_a = 1'b0;
    check("eot_hold", end_a, 1'b1);
    check("eot_nocap", cnt_a, 5'd0);
    ifa.dct_valid = 1'b0;

    // End of test on an empty buffer
    do_reset();
    te_a = 1'b1;
    tick();
    te_a = 1'b0;
    check("empty_ended_1", end_a, 1'b0);
    tick();
    check("empty_ended_2", end_a, 1'b1);

    // Reset mid-drain
    do_reset();
    for (int i = 0; i < 5; i++) push(30'(i + 50), 2'b01);
    te_a = 1'b1;
    tick();
    te_a = 1'b0;
    check("mid_count", cnt_a, 5'd5);
    do_reset();
    check("mid_rst_count", cnt_a, 5'd0);
    check("mid_rst_ended", end_a, 1'b0);
    push(30'h2A, 2'b01);
    check("mid_push_count", cnt_a, 5'd1);
    drain(0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
